// File: rtl/reg_file_if.sv
// reg_file_if: write/read port bundle between datapath stages and the register file
interface reg_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              rse;
  logic [ADDR_W-1:0] rsaddr;
  logic [DATA_W-1:0] rsdata;
  modport master (output we, waddr, wdata, rse, rsaddr, input rsdata);
  modport slave  (input we, waddr, wdata, rse, rsaddr, output rsdata);
endinterface

// File: rtl/reg_file.sv
// reg_file: 16x16 register file, one sync write port, one combinational read port with forwarding
module reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 2**ADDR_W
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);
  logic [DATA_W-1:0] regs [NREGS];
  // storage: async clear, single addressed write per edge; an unknown we never enables a write
  always_ff @(posedge clk or posedge rst)
    if (rst) regs <= '{default: '0};
    else if (bus.we) regs[bus.waddr] <= bus.wdata;
  // read: reset and disabled reads give zero, a same-address write is forwarded
  always_comb
    bus.rsdata = rst ? '0 :
                 !bus.rse ? '0 :
                 (bus.we && bus.rsaddr == bus.waddr) ? bus.wdata :
                 regs[bus.rsaddr];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file
module tb_reg_file;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  reg_file_if #(.DATA_W(16), .ADDR_W(4)) bus ();
  reg_file #(.DATA_W(16), .ADDR_W(4), .NREGS(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string tag);
    bus.rsaddr = a;
    #1;
    check($sformatf("%s_r%0d", tag, a), bus.rsdata, exp);
  endtask
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.we = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    @(negedge clk);
    bus.we = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.we = 1'b1;
    bus.waddr = 4'd1;
    bus.wdata = 16'hFFFF;
    bus.rse = 1'b1;
    bus.rsaddr = 4'd1;
    #1;
    check("reset_forward_blocked", bus.rsdata, 16'h0000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.we = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) rd(4'(i), 16'h0000, "after_reset");
    for (int i = 1; i < 16; i++) wr(4'(i), 16'(i));
    for (int i = 0; i < 16; i++) rd(4'(i), 16'(i), "write_read");
    wr(4'd5, 16'h1234);
    bus.rsaddr = 4'd5;
    bus.rse = 1'b0;
    #1;
    check("rse_off", bus.rsdata, 16'h0000);
    bus.rse = 1'b1;
    #1;
    check("rse_on", bus.rsdata, 16'h1234);
    wr(4'd3, 16'h00AA);
    rd(4'd3, 16'h00AA, "pre_fwd");
    bus.we = 1'b1;
    bus.waddr = 4'd3;
    bus.wdata = 16'h5555;
    #1;
    check("fwd_before_edge", bus.rsdata, 16'h5555);
    @(negedge clk);
    bus.we = 1'b0;
    #1;
    check("fwd_after_edge", bus.rsdata, 16'h5555);
    bus.we = 1'b1;
    bus.waddr = 4'd4;
    bus.wdata = 16'h9999;
    #1;
    check("iso_r3_during", bus.rsdata, 16'h5555);
    @(negedge clk);
    bus.we = 1'b0;
    rd(4'd3, 16'h5555, "iso_after");
    rd(4'd4, 16'h9999, "iso_after");
    bus.we = 1'b0;
    bus.waddr = 4'd7;
    bus.wdata = 16'hDEAD;
    repeat (10) @(negedge clk);
    rd(4'd7, 16'h0007, "we0_hold");
    wr(4'd9, 16'h1111);
    wr(4'd9, 16'h2222);
    rd(4'd9, 16'h2222, "last_wins");
    wr(4'd0, 16'h8001);
    rd(4'd0, 16'h8001, "r0_writable");
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.rsaddr = 4'd9;
    #1;
    check("rsdata_in_reset", bus.rsdata, 16'h0000);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.rsaddr = 4'(i);
      #0.1;
      check($sformatf("async_clear_r%0d", i), bus.rsdata, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.we = 1'b1;
    bus.waddr = 4'd2;
    bus.wdata = 16'hABCD;
    @(negedge clk);
    rst = 1'b0;
    bus.we = 1'b0;
    rd(4'd2, 16'h0000, "write_dropped_in_reset");
    wr(4'd2, 16'hBEEF);
    rd(4'd2, 16'hBEEF, "first_write_after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
